// File: rtl/riscv_hwloop_regs_pkg.sv
// Shared types and write-enable bit positions for the hardware-loop registers.
package riscv_hwlp_pkg;

  localparam int HWLP_WE_START = 0;
  localparam int HWLP_WE_END   = 1;
  localparam int HWLP_WE_CNT   = 2;

  typedef logic [31:0] hwlp_addr_t;
  typedef logic [31:0] hwlp_cnt_t;

  function automatic hwlp_addr_t hwlp_align(hwlp_addr_t a);
    return {a[31:1], 1'b0};
  endfunction

endpackage

// File: rtl/riscv_hwloop_regs_if.sv
// ID/controller <-> hardware-loop register file bundle.
// Optional flush input appears when RISCV_HWLP_FLUSH_EN is defined.
interface riscv_hwloop_regs_if
  import riscv_hwlp_pkg::*;
#(
  parameter int N_REGS     = 2,
  parameter int N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1
);

  hwlp_addr_t                   hwlp_start_data_i;
  hwlp_addr_t                   hwlp_end_data_i;
  hwlp_cnt_t                    hwlp_cnt_data_i;
  logic [2:0]                   hwlp_we_i;
  logic [N_REG_BITS-1:0]        hwlp_regid_i;
  logic                         valid_i;
  logic [N_REGS-1:0]            hwlp_dec_cnt_i;
  logic                         id_valid_i;
`ifdef RISCV_HWLP_FLUSH_EN
  logic                         hwlp_flush_i;
`endif
  logic [N_REGS-1:0][31:0]      hwlp_start_addr_o;
  logic [N_REGS-1:0][31:0]      hwlp_end_addr_o;
  logic [N_REGS-1:0][31:0]      hwlp_counter_o;
  logic [N_REGS-1:0]            hwlp_dec_cnt_id_o;

  modport master (
    output hwlp_start_data_i, hwlp_end_data_i, hwlp_cnt_data_i,
    output hwlp_we_i, hwlp_regid_i, valid_i,
    output hwlp_dec_cnt_i, id_valid_i,
`ifdef RISCV_HWLP_FLUSH_EN
    output hwlp_flush_i,
`endif
    input  hwlp_start_addr_o, hwlp_end_addr_o,
    input  hwlp_counter_o, hwlp_dec_cnt_id_o
  );

  modport slave (
    input  hwlp_start_data_i, hwlp_end_data_i, hwlp_cnt_data_i,
    input  hwlp_we_i, hwlp_regid_i, valid_i,
    input  hwlp_dec_cnt_i, id_valid_i,
`ifdef RISCV_HWLP_FLUSH_EN
    input  hwlp_flush_i,
`endif
    output hwlp_start_addr_o, hwlp_end_addr_o,
    output hwlp_counter_o, hwlp_dec_cnt_id_o
  );

endinterface

// File: rtl/riscv_hwloop_cnt_slice.sv
// One loop's iteration counter plus its decrement-in-flight bit.
// Flush input exists only with RISCV_HWLP_FLUSH_EN.
module riscv_hwloop_cnt_slice
  import riscv_hwlp_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  hwlp_cnt_t cnt_data,
  input  logic      cnt_we,
  input  logic      dec,
  input  logic      valid,
  input  logic      id_valid,
`ifdef RISCV_HWLP_FLUSH_EN
  input  logic      flush,
`endif
  output hwlp_cnt_t counter,
  output logic      dec_id
);

  logic do_dec;

  // saturate at zero so a spurious decrement never wraps
  assign do_dec = dec & valid & (counter != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter <= '0;
      dec_id  <= 1'b0;
    end
`ifdef RISCV_HWLP_FLUSH_EN
    else if (flush) begin
      counter <= '0;
      dec_id  <= 1'b0;
    end
`endif
    else begin
      if (cnt_we)
        counter <= cnt_data;
      else if (do_dec)
        counter <= counter - 32'd1;

      // a new instruction entering ID always wins
      if (valid)
        dec_id <= dec;
      else if (id_valid || cnt_we)
        dec_id <= 1'b0;
    end
  end

endmodule

// File: rtl/riscv_hwloop_regs.sv
// Hardware-loop start/end/counter register file.
// Define RISCV_HWLP_FLUSH_EN to add a counter flush input.
module riscv_hwloop_regs
  import riscv_hwlp_pkg::*;
#(
  parameter int N_REGS     = 2,
  parameter int N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1
)(
  input logic               clk,
  input logic               rst,
  riscv_hwloop_regs_if.slave bus
);

  hwlp_addr_t        start_q [N_REGS];
  hwlp_addr_t        end_q   [N_REGS];
  hwlp_cnt_t         cnt_q   [N_REGS];
  logic              dec_id_q[N_REGS];
  logic [N_REGS-1:0] sel;

  // out-of-range indices match no loop, so the write is dropped
  always_comb begin
    sel = '0;
    for (int i = 0; i < N_REGS; i++)
      sel[i] = (int'(bus.hwlp_regid_i) == i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_REGS; i++) begin
        start_q[i] <= '0;
        end_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_REGS; i++) begin
        if (sel[i] && bus.hwlp_we_i[HWLP_WE_START])
          start_q[i] <= hwlp_align(bus.hwlp_start_data_i);
        if (sel[i] && bus.hwlp_we_i[HWLP_WE_END])
          end_q[i] <= hwlp_align(bus.hwlp_end_data_i);
      end
    end
  end

  for (genvar i = 0; i < N_REGS; i++) begin : g_cnt
    riscv_hwloop_cnt_slice u_slice (
      .clk      (clk),
      .rst      (rst),
      .cnt_data (bus.hwlp_cnt_data_i),
      .cnt_we   (sel[i] & bus.hwlp_we_i[HWLP_WE_CNT]),
      .dec      (bus.hwlp_dec_cnt_i[i]),
      .valid    (bus.valid_i),
      .id_valid (bus.id_valid_i),
`ifdef RISCV_HWLP_FLUSH_EN
      .flush    (bus.hwlp_flush_i),
`endif
      .counter  (cnt_q[i]),
      .dec_id   (dec_id_q[i])
    );
  end

  always_comb begin
    bus.hwlp_start_addr_o = '0;
    bus.hwlp_end_addr_o   = '0;
    bus.hwlp_counter_o    = '0;
    bus.hwlp_dec_cnt_id_o = '0;
    for (int i = 0; i < N_REGS; i++) begin
      bus.hwlp_start_addr_o[i] = start_q[i];
      bus.hwlp_end_addr_o[i]   = end_q[i];
      bus.hwlp_counter_o[i]    = cnt_q[i];
      bus.hwlp_dec_cnt_id_o[i] = dec_id_q[i];
    end
  end

  a_dec_onehot: assert property (
    @(posedge clk) disable iff (rst) $onehot0(bus.hwlp_dec_cnt_i));

endmodule

// File: tb/tb_riscv_hwloop_regs.sv
// Self-checking bench for riscv_hwloop_regs (directed plan + random run).
// Flush test runs only when RISCV_HWLP_FLUSH_EN is defined.
module tb_riscv_hwloop_regs;

  localparam int N = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // reference state: plain arrays of architectural values
  logic [31:0] m_start [N];
  logic [31:0] m_end   [N];
  logic [31:0] m_cnt   [N];
  logic        m_inflt [N];

  riscv_hwloop_regs_if #(.N_REGS(N)) bus ();

  riscv_hwloop_regs #(.N_REGS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef RISCV_HWLP_FLUSH_EN
  assign bus.hwlp_flush_i = flush;
`endif

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_start[i] = 0; m_end[i] = 0; m_cnt[i] = 0; m_inflt[i] = 0;
    end
  endtask

  task automatic model_edge();
    int tgt;
    tgt = int'(bus.hwlp_regid_i);
    if (flush) begin
      for (int i = 0; i < N; i++) begin
        m_cnt[i] = 0; m_inflt[i] = 0;
      end
      return;
    end
    for (int i = 0; i < N; i++) begin
      bit wr_cnt;
      wr_cnt = (tgt == i) && bus.hwlp_we_i[2];
      if (tgt == i && bus.hwlp_we_i[0])
        m_start[i] = bus.hwlp_start_data_i & ~32'h1;
      if (tgt == i && bus.hwlp_we_i[1])
        m_end[i] = bus.hwlp_end_data_i & ~32'h1;
      if (wr_cnt)
        m_cnt[i] = bus.hwlp_cnt_data_i;
      else if (bus.valid_i && bus.hwlp_dec_cnt_i[i] && m_cnt[i] > 0)
        m_cnt[i] = m_cnt[i] - 1;
      if (bus.valid_i)
        m_inflt[i] = bus.hwlp_dec_cnt_i[i];
      else if (bus.id_valid_i || wr_cnt)
        m_inflt[i] = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".start"}, bus.hwlp_start_addr_o, {m_start[1], m_start[0]});
    chk({tag, ".end"}, bus.hwlp_end_addr_o, {m_end[1], m_end[0]});
    chk({tag, ".cnt"}, bus.hwlp_counter_o, {m_cnt[1], m_cnt[0]});
    chk({tag, ".decid"}, {62'd0, bus.hwlp_dec_cnt_id_o},
        {62'd0, m_inflt[1], m_inflt[0]});
  endtask

  task automatic idle();
    bus.hwlp_we_i         = 3'b000;
    bus.hwlp_regid_i      = 1'b0;
    bus.hwlp_start_data_i = 32'h0;
    bus.hwlp_end_data_i   = 32'h0;
    bus.hwlp_cnt_data_i   = 32'h0;
    bus.hwlp_dec_cnt_i    = 2'b00;
    bus.valid_i           = 1'b0;
    bus.id_valid_i        = 1'b0;
    flush                 = 1'b0;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic wr_cnt(input logic r, input logic [31:0] d);
    idle();
    bus.hwlp_regid_i = r; bus.hwlp_we_i = 3'b100; bus.hwlp_cnt_data_i = d;
    tick("wrcnt");
  endtask

  initial begin
    model_reset();
    idle();
    #1;
    check_all("reset");
    tick("reset_hold");
    #2 rst = 1'b0;

    // lp.setup on loop0
    bus.hwlp_regid_i = 1'b0; bus.hwlp_we_i = 3'b111;
    bus.hwlp_start_data_i = 32'h100;
    bus.hwlp_end_data_i = 32'h11D;
    bus.hwlp_cnt_data_i = 32'd3;
    tick("setup");
    chk("setup.end_align", {32'd0, bus.hwlp_end_addr_o[0]}, 64'h11C);
    chk("setup.cnt", {32'd0, bus.hwlp_counter_o[0]}, 64'd3);

    idle();
    bus.hwlp_dec_cnt_i = 2'b01; bus.valid_i = 1'b1;
    for (int k = 0; k < 4; k++) tick("dec_loop0");
    chk("dec.saturate", {32'd0, bus.hwlp_counter_o[0]}, 64'd0);

    // stall gating on loop1
    wr_cnt(1'b1, 32'd8);
    idle();
    bus.hwlp_dec_cnt_i = 2'b10;
    for (int k = 0; k < 4; k++) tick("stall");
    bus.valid_i = 1'b1;
    tick("stall_release");
    chk("stall.once", {32'd0, bus.hwlp_counter_o[1]}, 64'd7);
    idle();
    for (int k = 0; k < 2; k++) tick("inflt_hold");
    chk("inflt.hold", {62'd0, bus.hwlp_dec_cnt_id_o}, 64'b10);
    bus.id_valid_i = 1'b1;
    tick("inflt_clear");
    chk("inflt.clear", {62'd0, bus.hwlp_dec_cnt_id_o}, 64'b00);

    // write/decrement collisions
    wr_cnt(1'b0, 32'd7);
    bus.hwlp_cnt_data_i = 32'd10; bus.hwlp_regid_i = 1'b0;
    bus.hwlp_dec_cnt_i = 2'b01; bus.valid_i = 1'b1;
    tick("coll_same");
    chk("coll.write_wins", {32'd0, bus.hwlp_counter_o[0]}, 64'd10);
    wr_cnt(1'b0, 32'd7);
    bus.hwlp_cnt_data_i = 32'd10; bus.hwlp_regid_i = 1'b1;
    bus.hwlp_dec_cnt_i = 2'b01; bus.valid_i = 1'b1;
    tick("coll_other");
    chk("coll.both", bus.hwlp_counter_o, {32'd10, 32'd6});

    idle();
    bus.hwlp_dec_cnt_i = 2'b10; bus.valid_i = 1'b1; bus.id_valid_i = 1'b1;
    tick("load_wins");
    chk("load_wins", {62'd0, bus.hwlp_dec_cnt_id_o}, 64'b10);

`ifdef RISCV_HWLP_FLUSH_EN
    wr_cnt(1'b0, 32'd4);
    wr_cnt(1'b1, 32'd9);
    bus.hwlp_we_i = 3'b000;
    bus.hwlp_dec_cnt_i = 2'b01; bus.valid_i = 1'b1; flush = 1'b1;
    tick("flush");
    chk("flush.cnt", bus.hwlp_counter_o, 64'd0);
    chk("flush.start", {32'd0, bus.hwlp_start_addr_o[0]}, 64'h100);
    idle();
`endif

    // asynchronous reset mid-operation
    wr_cnt(1'b0, 32'd5);
    idle();
    bus.hwlp_dec_cnt_i = 2'b01; bus.valid_i = 1'b1;
    tick("pre_rst");
    #2 rst = 1'b1;
    idle();
    model_reset();
    #1;
    check_all("async_rst");
    tick("rst_held");
    #3 rst = 1'b0;
    for (int k = 0; k < 2; k++) tick("post_rst");

    // random run against the reference model
    for (int k = 0; k < 400; k++) begin
      int d;
      idle();
      bus.hwlp_we_i = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
      bus.hwlp_regid_i = 1'($urandom);
      bus.hwlp_start_data_i = $urandom;
      bus.hwlp_end_data_i = $urandom;
      bus.hwlp_cnt_data_i = 32'($urandom_range(0, 5));
      d = $urandom_range(0, 2);
      bus.hwlp_dec_cnt_i = (d == 0) ? 2'b00 : (d == 1) ? 2'b01 : 2'b10;
      bus.valid_i = 1'($urandom);
      bus.id_valid_i = 1'($urandom);
`ifdef RISCV_HWLP_FLUSH_EN
      flush = ($urandom_range(0, 31) == 0);
`endif
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_hwloop_regs.md
Name: riscv_hwloop_regs

Overview:
- Register file for the hardware-loop unit: holds start address, end address and iteration counter per loop.
- Written by the ID stage (lp.starti/endi/count/setup instructions and CSR writes). Decremented by the hwloop controller when fetch leaves a loop-end PC.
- Drives the controller's address/counter inputs.
- Tracks which loops have a decrement in flight for the instruction currently in ID; the controller uses this to resolve the counter==2 corner case.

Parameters:
- N_REGS, 2, number of hardware loops.
- N_REG_BITS, $clog2(N_REGS) (minimum 1), width of the loop index.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- hwlp_start_data_i  in  32  start address write data
- hwlp_end_data_i  in  32  end address write data
- hwlp_cnt_data_i  in  32  counter write data
- hwlp_we_i  in  3  write enables: [0] start, [1] end, [2] counter
- hwlp_regid_i  in  N_REG_BITS  loop index targeted by writes
- valid_i  in  1  instruction in IF accepted into ID this cycle
- hwlp_dec_cnt_i  in  N_REGS  decrement request from controller (one-hot or zero)
- id_valid_i  in  1  instruction in ID retires to EX this cycle
- hwlp_start_addr_o  out  N_REGS x 32  per-loop start address
- hwlp_end_addr_o  out  N_REGS x 32  per-loop end address
- hwlp_counter_o  out  N_REGS x 32  per-loop remaining iteration count
- hwlp_dec_cnt_id_o  out  N_REGS  decrement in flight for instruction in ID

Behaviour:
- Reset (async, rst=1): all start/end/counter registers = 32'h0; hwlp_dec_cnt_id_o = '0. Outputs are direct register values, so outputs read 0 while reset is asserted.
- Writes, 1-cycle latency: on the clk edge with hwlp_we_i[k]=1, the selected field of loop hwlp_regid_i takes the data. Visible on outputs the next cycle.
- Start/end writes force bit0 to 0 (halfword alignment); bit1 is kept.
- Any combination of the three enables may be set in one cycle (lp.setup writes all three).
- hwlp_regid_i >= N_REGS: write ignored.
- Decrement: counter[i] <= counter[i] - 1 when hwlp_dec_cnt_i[i] & valid_i.
  - Counter 0: stays 0, no wrap to 32'hFFFF_FFFF.
  - Decrement without valid_i (fetch stalled): ignored.
- Same-cycle counter write and decrement on the same loop: the write wins, the decrement is dropped.
- Decrement on loop A with a write to loop B: both take effect.
- More than one hwlp_dec_cnt_i bit set is illegal. Assertion in simulation; RTL decrements every flagged loop.
- In-flight tracking (hwlp_dec_cnt_id_o), per loop:
  - valid_i=1: load hwlp_dec_cnt_i.
  - else if id_valid_i=1: clear to 0.
  - else: hold.
  - valid_i and id_valid_i together: load wins (the new instruction enters ID).
- Counter write on loop i clears hwlp_dec_cnt_id_o[i] the same edge unless a new decrement is being loaded for loop i.
- No state machine beyond the per-loop registers. All updates are single-edge; no multi-cycle operations.

Optional Feature:
- Macro: RISCV_HWLP_FLUSH_EN.
- Defined:
  - Extra input hwlp_flush_i (1 bit).
  - When high at a clk edge: every counter <= 0 and hwlp_dec_cnt_id_o <= 0. Start/end registers are kept.
  - Flush has priority over writes and decrements in that cycle. Used on exception/debug entry to kill active loops.
- Undefined: the port is absent; counters change only by write, decrement or reset.

Decomposition:
- Package riscv_hwlp_pkg:
  - HWLP_WE_START=0, HWLP_WE_END=1, HWLP_WE_CNT=2 (bit positions of hwlp_we_i).
  - typedef hwlp_addr_t (logic [31:0]).
  - typedef hwlp_cnt_t (logic [31:0]).
- One natural sub-module: riscv_hwloop_cnt_slice, instantiated N_REGS times.
  - Contents: one loop's counter with write/decrement/saturation/flush priority, plus its in-flight bit.
  - Address registers stay in the top.

Test Plan:
- Reset mid-operation: counter[0]=5, dec in progress, assert rst asynchronously between edges -> all outputs 0 immediately, and stay 0 until the first write after release.
- Setup then loop: write loop0 start=32'h100, end=32'h11D, cnt=3 (we=3'b111) -> next cycle outputs 32'h100 / 32'h11C / 3. Three decrements with valid_i=1 -> counter 2, 1, 0. A fourth decrement -> stays 0.
- Stall gating: hwlp_dec_cnt_i=2'b10, valid_i=0 for 4 cycles, then valid_i=1 -> counter[1] decrements exactly once. hwlp_dec_cnt_id_o[1] is 1 from that edge until the first cycle with id_valid_i=1 and valid_i=0.
- Write/dec collision: counter[0]=7, same cycle cnt write of 10 to loop0 plus dec on loop0 -> 10. Write to loop1 plus dec on loop0 -> loop1=10, loop0=6.
- Simultaneous valid_i and id_valid_i with dec on loop1 -> hwlp_dec_cnt_id_o=2'b10, not cleared.
- With RISCV_HWLP_FLUSH_EN: counters 4/9 and a flush in the same cycle as a decrement -> counters 0/0, dec_id 0, start/end unchanged. Without the macro, the bench build omits the port and the test is skipped.
